// File: rtl/lbmem_stream.sv
// Line-delay buffer: holds writes until len_q words have accumulated, then
// streams them oldest-first with consumer back-pressure and synchronous flush.
//
// state  | meaning
// FILL   | accumulating words, no output; len_q tracks len while empty
// STREAM | oldest word presented on rdata; emitted when ready
module lbmem_stream #(
  parameter int WIDTH = 8,
  parameter int AW    = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wen,
  input  logic             ready,
  input  logic             flush,
  input  logic [AW:0]      len,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic [AW:0]      occ
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  typedef enum logic {FILL, STREAM} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    waddr, raddr;
  logic [AW:0]      occ_next, len_q, len_eff;
  logic             wacc, emit;

  assign full  = (occ == DEPTH_V);
  assign wacc  = wen & ~full & ~flush;
  // Oldest word sits occ entries behind the write pointer; when full this
  // wraps back onto waddr itself.
  assign raddr = waddr - occ[AW-1:0];
  assign rdata = mem[raddr];

  always_comb begin
    len_eff = len;
    if (len == '0)
      len_eff = (AW+1)'(1);
    else if (len > DEPTH_V)
      len_eff = DEPTH_V;
  end

  always_comb begin
    state_next = state;
    valid      = 1'b0;
    emit       = 1'b0;
    occ_next   = occ + {{AW{1'b0}}, wacc};
    case (state)
      FILL: begin
        if (occ_next == len_q)
          state_next = STREAM;
      end
      STREAM: begin
        valid    = 1'b1;
        emit     = ready & ~flush;
        occ_next = occ + {{AW{1'b0}}, wacc} - {{AW{1'b0}}, emit};
        if (occ_next == '0)
          state_next = FILL;
      end
      default: state_next = FILL;
    endcase
    if (flush) begin
      occ_next   = '0;
      state_next = FILL;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= FILL;
      occ   <= '0;
      waddr <= '0;
      len_q <= (AW+1)'(1);
    end else begin
      state <= state_next;
      occ   <= occ_next;
      if (wacc)
        waddr <= waddr + 1'b1;
      if (state == FILL && occ == '0)
        len_q <= len_eff;
    end
  end

  always_ff @(posedge CLK) begin
    if (wacc)
      mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_lbmem_stream.sv
// Directed bench for lbmem_stream: delay, drain, back-pressure/full,
// len change while busy, flush across pointer wrap, async reset.
module tb_lbmem_stream;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] wdata = '0;
  logic       wen = 1'b0;
  logic       ready = 1'b0;
  logic       flush = 1'b0;
  logic [6:0] len = 7'd1;
  logic [7:0] rdata;
  logic       valid;
  logic       full;
  logic [6:0] occ;

  int tests = 0;
  int fails = 0;

  lbmem_stream #(.WIDTH(8), .AW(6)) dut (
    .CLK(CLK), .RESET(RESET), .wdata(wdata), .wen(wen), .ready(ready),
    .flush(flush), .len(len), .rdata(rdata), .valid(valid), .full(full),
    .occ(occ)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #3;
    tests++;
    if (valid !== 1'b0 || full !== 1'b0 || occ !== 7'd0) begin
      fails++;
      $display("FAIL reset: valid=%b full=%b occ=%0d, want 0 0 0", valid, full, occ);
    end
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_stream_delay();
    len = 7'd8; ready = 1'b1; wen = 1'b0;
    tick();
    for (int c = 0; c < 20; c++) begin
      wen = 1'b1; wdata = 8'(c);
      tests++;
      if (valid !== (c >= 8) || occ !== 7'((c < 8) ? c : 8)) begin
        fails++;
        $display("FAIL delay c=%0d: valid=%b occ=%0d, want %b %0d", c, valid, occ, (c >= 8), (c < 8) ? c : 8);
      end
      if (c >= 8) begin
        tests++;
        if (rdata !== 8'(c - 8)) begin
          fails++;
          $display("FAIL delay_data c=%0d: rdata=%0d want %0d", c, rdata, c - 8);
        end
      end
      tick();
    end
  endtask

  task automatic test_drain();
    for (int c = 20; c <= 28; c++) begin
      wen = 1'b0;
      tests++;
      if (valid !== (c <= 27) || occ !== 7'(28 - c)) begin
        fails++;
        $display("FAIL drain c=%0d: valid=%b occ=%0d, want %b %0d", c, valid, occ, (c <= 27), 28 - c);
      end
      if (c <= 27) begin
        tests++;
        if (rdata !== 8'(c - 8)) begin
          fails++;
          $display("FAIL drain_data c=%0d: rdata=%0d want %0d", c, rdata, c - 8);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    len = 7'd4; ready = 1'b0; wen = 1'b0;
    tick();
    for (int i = 0; i < 70; i++) begin
      wen = 1'b1; wdata = 8'(i);
      tests++;
      if (occ !== 7'((i < 64) ? i : 64) || full !== (i >= 64) || valid !== (i >= 4)) begin
        fails++;
        $display("FAIL bp_fill i=%0d: occ=%0d full=%b valid=%b, want %0d %b %b", i, occ, full, valid, (i < 64) ? i : 64, (i >= 64), (i >= 4));
      end
      if (i >= 4) begin
        tests++;
        if (rdata !== 8'd0) begin
          fails++;
          $display("FAIL bp_hold i=%0d: rdata=%0d want 0", i, rdata);
        end
      end
      tick();
    end
    wen = 1'b0; ready = 1'b1;
    for (int j = 0; j < 64; j++) begin
      tests++;
      if (valid !== 1'b1 || rdata !== 8'(j) || occ !== 7'(64 - j)) begin
        fails++;
        $display("FAIL bp_drain j=%0d: valid=%b rdata=%0d occ=%0d, want 1 %0d %0d", j, valid, rdata, occ, j, 64 - j);
      end
      tick();
    end
    tests++;
    if (valid !== 1'b0 || occ !== 7'd0 || full !== 1'b0) begin
      fails++;
      $display("FAIL bp_empty: valid=%b occ=%0d full=%b, want 0 0 0", valid, occ, full);
    end
  endtask

  task automatic test_len_change();
    len = 7'd8; ready = 1'b1; wen = 1'b0;
    tick();
    for (int c = 0; c <= 20; c++) begin
      wen = (c < 12); wdata = 8'(8'h40 + c);
      if (c == 10) len = 7'd3;
      tests++;
      if (valid !== (c >= 8 && c <= 19)) begin
        fails++;
        $display("FAIL lenchg c=%0d: valid=%b want %b", c, valid, (c >= 8 && c <= 19));
      end
      if (c >= 8 && c <= 19) begin
        tests++;
        if (rdata !== 8'(8'h40 + c - 8)) begin
          fails++;
          $display("FAIL lenchg_data c=%0d: rdata=%0h want %0h", c, rdata, 8'h40 + c - 8);
        end
      end
      tick();
    end
    for (int c = 0; c <= 9; c++) begin
      wen = (c < 6); wdata = 8'(8'h60 + c);
      tests++;
      if (valid !== (c >= 3 && c <= 8)) begin
        fails++;
        $display("FAIL len3 c=%0d: valid=%b want %b", c, valid, (c >= 3 && c <= 8));
      end
      if (c >= 3 && c <= 8) begin
        tests++;
        if (rdata !== 8'(8'h60 + c - 3)) begin
          fails++;
          $display("FAIL len3_data c=%0d: rdata=%0h want %0h", c, rdata, 8'h60 + c - 3);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush_wrap();
    // waddr is 38 here; 24 writes bring it to 62 before the flush
    len = 7'd8; ready = 1'b1; wen = 1'b0;
    tick();
    for (int c = 0; c < 24; c++) begin
      wen = 1'b1; wdata = 8'(8'h10 + c);
      if (c >= 8) begin
        tests++;
        if (valid !== 1'b1 || rdata !== 8'(8'h10 + c - 8)) begin
          fails++;
          $display("FAIL pre_flush c=%0d: valid=%b rdata=%0h want 1 %0h", c, valid, rdata, 8'h10 + c - 8);
        end
      end
      tick();
    end
    wen = 1'b1; wdata = 8'hEE; flush = 1'b1;
    tick();
    flush = 1'b0; wen = 1'b0; len = 7'd5;
    tests++;
    if (valid !== 1'b0 || occ !== 7'd0) begin
      fails++;
      $display("FAIL flush: valid=%b occ=%0d, want 0 0", valid, occ);
    end
    tick();
    for (int c = 0; c <= 15; c++) begin
      wen = (c < 10); wdata = 8'(8'hA0 + c);
      tests++;
      if (valid !== (c >= 5 && c <= 14)) begin
        fails++;
        $display("FAIL refill c=%0d: valid=%b want %b", c, valid, (c >= 5 && c <= 14));
      end
      if (c >= 5 && c <= 14) begin
        tests++;
        if (rdata !== 8'(8'hA0 + c - 5)) begin
          fails++;
          $display("FAIL refill_data c=%0d: rdata=%0h want %0h", c, rdata, 8'hA0 + c - 5);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    len = 7'd8; ready = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      wen = 1'b1; wdata = 8'(8'h20 + c);
      tick();
    end
    wen = 1'b0;
    tests++;
    if (valid !== 1'b1 || occ !== 7'd8) begin
      fails++;
      $display("FAIL pre_reset: valid=%b occ=%0d, want 1 8", valid, occ);
    end
    #3;
    RESET = 1'b1;
    #1;
    tests++;
    if (valid !== 1'b0 || occ !== 7'd0 || full !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: valid=%b occ=%0d full=%b, want 0 0 0", valid, occ, full);
    end
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    len = 7'd0;
    tick();
    tick();
    for (int c = 0; c <= 9; c++) begin
      wen = (c < 8); wdata = 8'(8'h30 + c);
      tests++;
      if (valid !== (c >= 1 && c <= 8) || occ !== 7'((c >= 1 && c <= 8) ? 1 : 0)) begin
        fails++;
        $display("FAIL len0 c=%0d: valid=%b occ=%0d, want %b %0d", c, valid, occ, (c >= 1 && c <= 8), (c >= 1 && c <= 8) ? 1 : 0);
      end
      if (c >= 1 && c <= 8) begin
        tests++;
        if (rdata !== 8'(8'h30 + c - 1)) begin
          fails++;
          $display("FAIL len0_data c=%0d: rdata=%0h want %0h", c, rdata, 8'h30 + c - 1);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream_delay();
    test_drain();
    test_backpressure();
    test_len_change();
    test_flush_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
